// File: rtl/spu_pipe_pkg.sv
// Shared types for the SPU result-staging pipe.
// Slot entry layout and execution-unit ids.
package spu_pipe_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int UNIT_W = 2;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_FP   = 2'd0,
    UNIT_FX2  = 2'd1,
    UNIT_BYTE = 2'd2,
    UNIT_FX1  = 2'd3
  } unit_id_e;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [ADDR_W-1:0] addr;
    unit_id_e          unit;
    logic              ready;
    logic [DATA_W-1:0] data;
  } stage_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// Priority search of the staging slots for one source operand.
// The youngest (lowest-numbered) live producer decides the result.
module fwd_lookup
  import spu_pipe_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic [DEPTH:1]             i_live,
  input  logic [DEPTH:1]             i_ready,
  input  logic [DEPTH:1][ADDR_W-1:0] i_slot_addr,
  input  logic [DEPTH:1][DATA_W-1:0] i_slot_data,
  input  logic [ADDR_W-1:0]          i_addr,
  output logic                       o_hit,
  output logic                       o_stall,
  output logic [DATA_W-1:0]          o_data
);

  // Walk oldest to youngest so the youngest match is written last.
  always_comb begin
    o_hit   = 1'b0;
    o_stall = 1'b0;
    o_data  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (i_live[k] && (i_slot_addr[k] == i_addr)) begin
        o_hit   = i_ready[k];
        o_stall = ~i_ready[k];
        o_data  = i_ready[k] ? i_slot_data[k] : '0;
      end
    end
  end

endmodule

// File: rtl/result_stage_pipe.sv
// Result staging and forwarding pipe for one SPU issue pipe.
// Slots shift every cycle; units deposit results at their fixed latency.
module result_stage_pipe
  import spu_pipe_pkg::*;
#(
  parameter int                     DEPTH       = 7,
  parameter int                     NUM_UNITS   = 4,
  parameter logic [4*NUM_UNITS-1:0] UNIT_LAT    = 16'h2446,
  parameter int                     NUM_SRC     = 3,
  parameter int                     FLUSH_DEPTH = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                issue_valid,
  input  logic [$clog2(NUM_UNITS)-1:0]        issue_unit,
  input  logic [ADDR_W-1:0]                   issue_rt_addr,
  input  logic                                issue_reg_write,
  input  logic [NUM_UNITS-1:0]                unit_valid,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]    unit_data,
  input  logic                                flush,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]      src_addr,
  output logic [NUM_SRC-1:0]                  src_hit,
  output logic [NUM_SRC-1:0][DATA_W-1:0]      src_data,
  output logic [NUM_SRC-1:0]                  src_stall,
  output logic                                stall,
  output logic [DATA_W-1:0]                   rt_wb,
  output logic [ADDR_W-1:0]                   rt_addr_wb,
  output logic                                reg_write_wb,
  output logic                                lat_err,
  output logic                                unit_err
);

  function automatic int lat_of(input int u);
    return int'(UNIT_LAT[4*u +: 4]);
  endfunction

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_lat_chk
    if (lat_of(u) < 1 || lat_of(u) > DEPTH - 1) begin : g_bad
      $error("UNIT_LAT of unit %0d outside 1..DEPTH-1", u);
    end
  end

  if (NUM_UNITS < 2 || NUM_UNITS > 4) begin : g_bad_units
    $error("NUM_UNITS must be 2..4");
  end

  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > DEPTH - 2) begin : g_bad_flush
    $error("FLUSH_DEPTH must be 1..DEPTH-2");
  end

  stage_entry_t [DEPTH:1]   r_slot;
  logic [DEPTH-1:1]         r_kill;
  logic                     r_lat_err;
  logic                     r_unit_err;

  stage_entry_t [DEPTH:1]   w_nxt;
  logic [DEPTH-1:1]         w_kill;
  logic                     w_uerr;
  logic                     w_late;

  always_comb begin
    w_nxt  = '0;
    w_kill = '0;
    w_uerr = 1'b0;

    w_nxt[1].valid = issue_valid & ~flush;
    w_nxt[1].write = issue_reg_write;
    w_nxt[1].addr  = issue_rt_addr;
    w_nxt[1].unit  = unit_id_e'(UNIT_W'(issue_unit));
    w_kill[1]      = issue_valid & flush;

    for (int k = 2; k <= DEPTH; k++) begin
      w_nxt[k] = r_slot[k-1];
    end
    for (int k = 2; k <= DEPTH - 1; k++) begin
      w_kill[k] = r_kill[k-1];
    end

    // Results for entries already killed by a flush are dropped quietly.
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (unit_valid[u]) begin
        if (r_slot[lat_of(u)].valid &&
            r_slot[lat_of(u)].unit == unit_id_e'(u[UNIT_W-1:0])) begin
          w_nxt[lat_of(u)+1].data  = unit_data[u];
          w_nxt[lat_of(u)+1].ready = 1'b1;
        end else if (r_slot[lat_of(u)].valid || !r_kill[lat_of(u)]) begin
          w_uerr = 1'b1;
        end
      end
    end

    if (flush) begin
      for (int k = 2; k <= FLUSH_DEPTH + 1; k++) begin
        w_nxt[k].valid = 1'b0;
        w_kill[k]      = r_kill[k-1] | r_slot[k-1].valid;
      end
    end

    w_late = w_nxt[DEPTH].valid & w_nxt[DEPTH].write & ~w_nxt[DEPTH].ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot     <= '0;
      r_kill     <= '0;
      r_lat_err  <= 1'b0;
      r_unit_err <= 1'b0;
    end else begin
      r_slot <= w_nxt;
      r_kill <= w_kill;
      if (w_late) r_lat_err  <= 1'b1;
      if (w_uerr) r_unit_err <= 1'b1;
    end
  end

  logic [DEPTH:1]             w_live;
  logic [DEPTH:1]             w_ready;
  logic [DEPTH:1][ADDR_W-1:0] w_addr;
  logic [DEPTH:1][DATA_W-1:0] w_data;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_view
    assign w_live[k]  = r_slot[k].valid & r_slot[k].write;
    assign w_ready[k] = r_slot[k].ready;
    assign w_addr[k]  = r_slot[k].addr;
    assign w_data[k]  = r_slot[k].data;
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_lookup #(
      .DEPTH       (DEPTH)
    ) u_fwd (
      .i_live      (w_live),
      .i_ready     (w_ready),
      .i_slot_addr (w_addr),
      .i_slot_data (w_data),
      .i_addr      (src_addr[s]),
      .o_hit       (src_hit[s]),
      .o_stall     (src_stall[s]),
      .o_data      (src_data[s])
    );
  end

  logic w_unused;
  assign w_unused = ^r_slot[DEPTH].unit;

  assign stall        = |src_stall;
  assign rt_wb        = r_slot[DEPTH].data;
  assign rt_addr_wb   = r_slot[DEPTH].addr;
  assign reg_write_wb = r_slot[DEPTH].valid & r_slot[DEPTH].write &
                        r_slot[DEPTH].ready;
  assign lat_err      = r_lat_err;
  assign unit_err     = r_unit_err;

endmodule

// File: doc/result_stage_pipe.md
Name: result_stage_pipe

Overview:
- Parametrised result-staging and forwarding pipeline for one SPU issue pipe (even or odd).
- Tracks every issued instruction from issue to writeback and captures each execution unit's result at that unit's fixed latency.
- Serves forwarded values and RAW stalls for NUM_SRC source operands.
- Supports a branch flush of the youngest in-flight entries.
- Does not mux operands into the units. It only records destinations and collects results.

Parameters:
- DEPTH, 7: number of staging slots (1..DEPTH). Writeback occurs from slot DEPTH.
- NUM_UNITS, 4: number of execution units feeding the pipe.
- UNIT_LAT, {6,4,4,2}: per-unit result latency in cycles, as 4-bit fields indexed by unit id. Legal range 1..DEPTH-1; checked by elaboration assertion.
- NUM_SRC, 3: number of source-operand lookup ports.
- FLUSH_DEPTH, 3: slots 1..FLUSH_DEPTH are killed on flush.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction issued this cycle
- issue_unit  in  $clog2(NUM_UNITS)  target unit id
- issue_rt_addr  in  7  destination register
- issue_reg_write  in  1  instruction writes the register file
- unit_valid  in  NUM_UNITS  unit u presents a result this cycle
- unit_data  in  NUM_UNITS x 128  result data per unit
- flush  in  1  branch taken; kill young entries
- src_addr  in  NUM_SRC x 7  source register addresses to check
- src_hit  out  NUM_SRC  forwarded value available
- src_data  out  NUM_SRC x 128  forwarded value (0 when not hit)
- src_stall  out  NUM_SRC  youngest matching producer not ready yet
- stall  out  1  OR of src_stall
- rt_wb  out  128  writeback data
- rt_addr_wb  out  7  writeback address
- reg_write_wb  out  1  writeback enable
- lat_err  out  1  sticky error: entry reached slot DEPTH not ready
- unit_err  out  1  sticky error: unexpected or colliding unit result

Behaviour:
- Slot fields per entry: valid, write, addr[7], unit id, ready, data[128].
- Shift: slot[k+1] <= slot[k] every cycle, unconditionally; no back-pressure. slot[1] <= issue fields with ready=0 and data=0; valid=issue_valid.
- Timing: an instruction issued in cycle 0 sits in slot[k] during cycle k.
- Capture: unit u with L=UNIT_LAT[u] asserts unit_valid[u] in cycle L, while its entry is in slot[L]. At that edge, slot[L+1] takes data=unit_data[u] and ready=1.
- unit_valid[u] with slot[L] invalid, or with unit id ≠ u: result ignored, unit_err set.
- Two units with equal latency both valid in the same cycle: the one matching the entry's unit id wins; unit_err is set.
- Writeback: rt_wb and rt_addr_wb come from the slot[DEPTH] registers, unchanged in value. reg_write_wb = valid & write & ready.
- lat_err: set if slot[DEPTH] has valid & write & ~ready. Its reg_write_wb is 0.
- Lookup is combinational. For each source, search slots 1..DEPTH youngest-first (lowest k) for valid & write & addr==src_addr.
  - First match ready: src_hit=1, src_data=slot data.
  - First match not ready: src_stall=1.
  - No match: all outputs 0.
  - Older matches never override a younger match.
- Flush: at the edge, slots 2..FLUSH_DEPTH+1 receive valid=0. These are the entries that were in slots 1..FLUSH_DEPTH. The same-cycle issue is dropped (slot[1] valid=0). unit_valid for flushed entries is ignored without setting unit_err.
- Reset:
  - All slot fields, rt_wb, rt_addr_wb, reg_write_wb, lat_err and unit_err are cleared to 0 at the next edge.
  - src_* outputs and stall read 0 once slots are cleared.
  - Reset mid-operation discards all in-flight entries.
- Wrap: entries leave after slot DEPTH. Addresses are compared on all 7 bits; register 0 gets no special case.

Decomposition:
- Package spu_pipe_pkg:
  - DATA_W=128 and ADDR_W=7.
  - Unit id enum: FP=0, FX2=1, BYTE=2, FX1=3.
  - Packed struct stage_entry_t holding the slot fields.
- Sub-module fwd_lookup: one instance per source. Implements the priority search over the slot array and produces hit, stall and data.

Test Plan:
- Issue FX1 (lat 2), rt=5, write=1, at cycle 0; unit_valid[3] in cycle 2 with data 0xA5…A5 → src_addr=5 stalls in cycles 1–2, hits in cycles 3–7 with 0xA5…A5. reg_write_wb=1, rt_addr_wb=5 in cycle 7.
- Back-to-back issues: FP rt=9 at cycle 0, then FX1 rt=9 at cycle 1 with result at cycle 3 → lookup of 9 in cycle 4 returns the FX1 data (younger). In cycle 5, FP not ready but the younger match wins, so no stall.
- Flush in cycle 2 with entries issued at cycles 0, 1, 2 (FLUSH_DEPTH=3) → all three killed, no writebacks, later unit_valid for them ignored, unit_err=0.
- unit_valid[1] in a cycle where slot[4] is empty → unit_err=1 and stays high; no writeback occurs.
- Issue FP rt=12, withhold unit_valid[0] → cycle 7: lat_err=1, reg_write_wb=0.
- Assert reset in cycle 3 with four entries in flight → all outputs 0 from cycle 4; no writebacks afterwards.
